// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch/countdown timer.
//   state_e : control state encoding (PAUSE, RUN, EXPIRED)
//   ADJ_*   : adj_sel codes; 2'b11 is handled as minutes by the core
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StPause   = 2'b00,
    StRun     = 2'b01,
    StExpired = 2'b10
  } state_e;

  localparam logic [1:0] ADJ_NONE = 2'b00;
  localparam logic [1:0] ADJ_MIN  = 2'b01;
  localparam logic [1:0] ADJ_SEC  = 2'b10;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) up/down counter field used for both minutes and seconds.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc, dec   : count up / down by one (inc wins if both are set)
//   zero       : synchronous clear, highest priority
//   value      : registered count
//   carry      : combinational, high when this cycle's inc rolls MAX -> 0
//   borrow     : combinational, high when this cycle's dec rolls 0 -> MAX
module mod_counter #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         zero,
  output logic [W-1:0] value,
  output logic         carry,
  output logic         borrow
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    carry   = !zero && inc && (value_q == MaxVal);
    borrow  = !zero && !inc && dec && (value_q == '0);
    if (zero) begin
      value_d = '0;
    end else if (inc) begin
      value_d = carry ? '0 : value_q + 1'b1;
    end else if (dec) begin
      value_d = borrow ? MaxVal : value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/stopwatch_timer.sv
// Stopwatch / countdown timer core: minutes:seconds count with run/pause control,
// field adjust, up-count wrap pulse and down-count expiry.
//   clk, rst_n        : clock, asynchronous active-low reset
//   tick              : 1 Hz count enable pulse
//   adj_tick          : adjust-rate pulse, acts when adj_sel != ADJ_NONE
//   pause_tgl         : run/pause toggle pulse
//   clear             : synchronous clear to 0:00 / PAUSE
//   mode_down         : 0 count up, 1 count down (sampled per tick)
//   adj_sel           : field select for adjust
//   lap               : lap-hold toggle pulse
//   minutes, seconds  : displayed count
//   running, expired  : state flags
//   wrap              : one-cycle pulse on MIN_MAX:SEC_MAX -> 0:00 up-count
// Optional feature macro: STOPWATCH_LAP_HOLD_EN enables lap hold of the display;
// without it lap is ignored and the display always shows the live count.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int unsigned SEC_MAX = 59,
  parameter int unsigned MIN_MAX = 59,
  parameter int unsigned W       = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         adj_tick,
  input  logic         pause_tgl,
  input  logic         clear,
  input  logic         mode_down,
  input  logic [1:0]   adj_sel,
  input  logic         lap,
  output logic [W-1:0] minutes,
  output logic [W-1:0] seconds,
  output logic         running,
  output logic         expired,
  output logic         wrap
);

  localparam logic [W-1:0] SecMaxVal = W'(SEC_MAX);
  localparam logic [W-1:0] MinMaxVal = W'(MIN_MAX);

  state_e       state_q, state_d;
  logic         wrap_q, wrap_d;
  logic         cnt_zero, sec_adj, min_adj, tick_up, tick_dn;
  logic [W-1:0] sec_value, min_value;
  logic         sec_carry, sec_borrow;
  logic         unused_min_carry, unused_min_borrow;
  logic         count_is_zero;

  assign count_is_zero = (sec_value == '0) && (min_value == '0);

  // One event per cycle, in priority order: clear, pause_tgl, adjust, tick.
  always_comb begin
    state_d  = state_q;
    wrap_d   = 1'b0;
    cnt_zero = 1'b0;
    sec_adj  = 1'b0;
    min_adj  = 1'b0;
    tick_up  = 1'b0;
    tick_dn  = 1'b0;
    if (clear) begin
      cnt_zero = 1'b1;
      state_d  = StPause;
    end else if (pause_tgl) begin
      unique case (state_q)
        StPause:   state_d = (mode_down && count_is_zero) ? StExpired : StRun;
        StRun:     state_d = StPause;
        StExpired: state_d = StPause;
        default:   state_d = StPause;
      endcase
    end else if ((adj_sel != ADJ_NONE) && adj_tick && (state_q != StExpired)) begin
      if (adj_sel == ADJ_SEC) begin
        sec_adj = 1'b1;
      end else begin
        min_adj = 1'b1;
      end
    end else if (tick && (adj_sel == ADJ_NONE) && (state_q == StRun)) begin
      if (mode_down) begin
        tick_dn = 1'b1;
        // 0:01 -> 0:00 is the only decrement that lands on zero
        if ((min_value == '0) && (sec_value == W'(1))) begin
          state_d = StExpired;
        end
      end else begin
        tick_up = 1'b1;
        wrap_d  = (min_value == MinMaxVal) && (sec_value == SecMaxVal);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StPause;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end

  mod_counter #(
    .MAX (SEC_MAX),
    .W   (W)
  ) u_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (sec_adj | tick_up),
    .dec    (tick_dn),
    .zero   (cnt_zero),
    .value  (sec_value),
    .carry  (sec_carry),
    .borrow (sec_borrow)
  );

  // Seconds carry/borrow only ripple on ticks; a seconds adjust never touches minutes.
  mod_counter #(
    .MAX (MIN_MAX),
    .W   (W)
  ) u_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (min_adj | (tick_up & sec_carry)),
    .dec    (tick_dn & sec_borrow),
    .zero   (cnt_zero),
    .value  (min_value),
    .carry  (unused_min_carry),
    .borrow (unused_min_borrow)
  );

  assign running = (state_q == StRun);
  assign expired = (state_q == StExpired);
  assign wrap    = wrap_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic         hold_q, hold_d;
  logic [W-1:0] snap_min_q, snap_sec_q;

  always_comb begin
    hold_d = hold_q;
    if (clear || ((state_d == StExpired) && (state_q != StExpired))) begin
      hold_d = 1'b0;
    end else if (lap && (state_q != StExpired)) begin
      hold_d = !hold_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= 1'b0;
      snap_min_q <= '0;
      snap_sec_q <= '0;
    end else begin
      hold_q <= hold_d;
      if (hold_d && !hold_q) begin
        snap_min_q <= min_value;
        snap_sec_q <= sec_value;
      end
    end
  end

  assign minutes = hold_q ? snap_min_q : min_value;
  assign seconds = hold_q ? snap_sec_q : sec_value;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign minutes    = min_value;
  assign seconds    = sec_value;
`endif

endmodule
